barret_mul_feed: RTL and testbench

- Upstream feeder for the Barrett reducer in the modular-multiply datapath.
- Accepts operand pairs over a valid/ready handshake and computes the full 2*MAX_BW-bit product in a 3-stage pipeline. Issues product and valid to the reducer, which has no backpressure.
- Holds the reducer's static configuration (modulus q, packed sparse constant t, mode) and updates it only when the reducer path is drained.
- Flow control is credit-based; credits match the depth of the result buffer after the reducer.

---
 rtl/barret_mul_feed_pkg.sv | 29 ++
 rtl/barret_credit_ctr.sv | 49 ++++
 rtl/barret_mul_feed.sv | 198 +++++++++++++++++++
 tb/tb_barret_mul_feed.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barret_mul_feed_pkg.sv
// rtl/barret_mul_feed_pkg.sv - shared widths, packed-t layout and config FSM states for the Barrett feeder
package barret_mul_feed_pkg;

   localparam int MAX_BW      = 62;
   localparam int HALF_BW     = MAX_BW / 2;
   localparam int PROD_BW     = 2 * MAX_BW;
   localparam int RED_LATENCY = 4;

   // Packed t: six sign/index pairs (sign0/idx0, sign1/idx1, T sign/idx 0..3), LSB first
   localparam int T_IDX_BW   = 5;
   localparam int T_FIELD_BW = T_IDX_BW + 1;
   localparam int T_NPAIRS   = 6;
   localparam int T_USED_BW  = T_NPAIRS * T_FIELD_BW;

   typedef struct packed {
      logic [T_IDX_BW-1:0] idx;
      logic                sgn;
   } t_field_t;

   typedef enum logic [0:0] {
      CFG_IDLE = 1'b0,
      CFG_BUSY = 1'b1
   } cfg_state_t;

   function automatic t_field_t t_field(input logic [MAX_BW:0] t, input int k);
      return t[k*T_FIELD_BW +: T_FIELD_BW];
   endfunction

endpackage

// File: rtl/barret_credit_ctr.sv
// rtl/barret_credit_ctr.sv - downstream result-buffer credit counter with sticky overflow error
module barret_credit_ctr #(
   parameter int CREDITS = 4,
   parameter int CW      = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_take,
   input  logic i_ret,
   output logic o_avail,
   output logic o_full,
   output logic o_err
);

   logic [CW-1:0] r_credit;
   logic [CW-1:0] w_credit_nxt;
   logic          r_err;
   logic          w_full;
   logic          w_ret_ok;

   assign w_full   = (r_credit == CW'(CREDITS));
   // A return with nothing outstanding is bogus: it never adds a credit
   assign w_ret_ok = i_ret && !w_full;

   always_comb begin
      w_credit_nxt = r_credit;
      case ({i_take, w_ret_ok})
         2'b10:   w_credit_nxt = r_credit - CW'(1);
         2'b01:   w_credit_nxt = r_credit + CW'(1);
         default: w_credit_nxt = r_credit;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credit <= CW'(CREDITS);
         r_err    <= 1'b0;
      end else begin
         r_credit <= w_credit_nxt;
         if (i_ret && w_full)
            r_err <= 1'b1;
      end
   end

   assign o_avail = (r_credit != '0);
   assign o_full  = w_full;
   assign o_err   = r_err;

endmodule

// File: rtl/barret_mul_feed.sv
// rtl/barret_mul_feed.sv - 3-stage operand multiplier feeding the Barrett reducer, plus its held config
module barret_mul_feed
   import barret_mul_feed_pkg::*;
#(
   parameter int CREDITS = 4,
   parameter int CW      = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [MAX_BW-1:0]    s_a,
   input  logic [MAX_BW-1:0]    s_b,
   output logic                 m_valid,
   output logic [PROD_BW-1:0]   m_xy,
   input  logic                 i_credit_ret,
   input  logic                 cfg_we,
   input  logic [MAX_BW-1:0]    cfg_q,
   input  logic [MAX_BW:0]      cfg_t,
   input  logic                 cfg_mode,
   output logic [MAX_BW-1:0]    o_q,
   output logic [MAX_BW:0]      o_t,
   output logic                 o_mode,
   output logic                 cfg_busy,
   output logic                 cfg_done,
   output logic                 err_credit
);

   logic                w_accept;
   logic                w_credit_avail;
   logic                w_credit_full;
   logic                w_pipe_empty;
   logic                w_apply;

   cfg_state_t          r_cfg_state;
   cfg_state_t          w_cfg_state_nxt;

   logic [MAX_BW-1:0]   r_sh_q;
   logic [MAX_BW:0]     r_sh_t;
   logic                r_sh_mode;
   logic [MAX_BW-1:0]   r_q;
   logic [MAX_BW:0]     r_t;
   logic                r_mode;
   logic                r_cfg_done;

   logic                r_s1_valid;
   logic                r_s1_mode;
   logic [HALF_BW-1:0]  r_ah;
   logic [HALF_BW-1:0]  r_al;
   logic [HALF_BW-1:0]  r_bh;
   logic [HALF_BW-1:0]  r_bl;

   logic                r_s2_valid;
   logic                r_s2_mode;
   logic [MAX_BW-1:0]   r_hh;
   logic [MAX_BW-1:0]   r_hl;
   logic [MAX_BW-1:0]   r_lh;
   logic [MAX_BW-1:0]   r_ll;

   logic                r_s3_valid;
   logic [PROD_BW-1:0]  r_xy;

   logic [MAX_BW-1:0]   w_hh;
   logic [MAX_BW-1:0]   w_hl;
   logic [MAX_BW-1:0]   w_lh;
   logic [MAX_BW-1:0]   w_ll;
   logic [MAX_BW:0]     w_mid;
   logic [PROD_BW-1:0]  w_sum;

   assign s_ready      = w_credit_avail && !cfg_busy;
   assign w_accept     = s_valid && s_ready;
   assign w_pipe_empty = !r_s1_valid && !r_s2_valid && !r_s3_valid;

   barret_credit_ctr #(
      .CREDITS (CREDITS),
      .CW      (CW)
   ) u_credit (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_take  (w_accept),
      .i_ret   (i_credit_ret),
      .o_avail (w_credit_avail),
      .o_full  (w_credit_full),
      .o_err   (err_credit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cfg_state <= CFG_IDLE;
      else
         r_cfg_state <= w_cfg_state_nxt;
   end

   // A write landing in the apply cycle defers the apply so the newest shadow wins
   always_comb begin
      w_cfg_state_nxt = r_cfg_state;
      case (r_cfg_state)
         CFG_IDLE: if (cfg_we) w_cfg_state_nxt = CFG_BUSY;
         CFG_BUSY: if (!cfg_we && w_credit_full && w_pipe_empty) w_cfg_state_nxt = CFG_IDLE;
         default:  w_cfg_state_nxt = CFG_IDLE;
      endcase
   end

   always_comb begin
      cfg_busy = (r_cfg_state == CFG_BUSY);
      w_apply  = (r_cfg_state == CFG_BUSY) && !cfg_we && w_credit_full && w_pipe_empty;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_q     <= '0;
         r_sh_t     <= '0;
         r_sh_mode  <= 1'b0;
         r_q        <= '0;
         r_t        <= '0;
         r_mode     <= 1'b0;
         r_cfg_done <= 1'b0;
      end else begin
         if (cfg_we) begin
            r_sh_q    <= cfg_q;
            r_sh_t    <= cfg_t;
            r_sh_mode <= cfg_mode;
         end
         if (w_apply) begin
            r_q    <= r_sh_q;
            r_t    <= r_sh_t;
            r_mode <= r_sh_mode;
         end
         r_cfg_done <= w_apply;
      end
   end

   assign o_q      = r_q;
   assign o_t      = r_t;
   assign o_mode   = r_mode;
   assign cfg_done = r_cfg_done;

   assign w_hh  = {{HALF_BW{1'b0}}, r_ah} * {{HALF_BW{1'b0}}, r_bh};
   assign w_hl  = {{HALF_BW{1'b0}}, r_ah} * {{HALF_BW{1'b0}}, r_bl};
   assign w_lh  = {{HALF_BW{1'b0}}, r_al} * {{HALF_BW{1'b0}}, r_bh};
   assign w_ll  = {{HALF_BW{1'b0}}, r_al} * {{HALF_BW{1'b0}}, r_bl};
   // {hh,ll} already equals hh<<MAX_BW + ll since ll fits in MAX_BW bits
   assign w_mid = {1'b0, r_hl} + {1'b0, r_lh};
   assign w_sum = {r_hh, r_ll} + ({{(MAX_BW-1){1'b0}}, w_mid} << HALF_BW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_mode  <= 1'b0;
         r_ah       <= '0;
         r_al       <= '0;
         r_bh       <= '0;
         r_bl       <= '0;
         r_s2_valid <= 1'b0;
         r_s2_mode  <= 1'b0;
         r_hh       <= '0;
         r_hl       <= '0;
         r_lh       <= '0;
         r_ll       <= '0;
         r_s3_valid <= 1'b0;
         r_xy       <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_mode <= r_mode;
            r_ah      <= s_a[MAX_BW-1:HALF_BW];
            r_al      <= s_a[HALF_BW-1:0];
            r_bh      <= s_b[MAX_BW-1:HALF_BW];
            r_bl      <= s_b[HALF_BW-1:0];
         end

         // Passthrough reuses hh/ll to carry a and b so S3 only concatenates
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_mode <= r_s1_mode;
            if (r_s1_mode) begin
               r_hh <= {r_ah, r_al};
               r_hl <= '0;
               r_lh <= '0;
               r_ll <= {r_bh, r_bl};
            end else begin
               r_hh <= w_hh;
               r_hl <= w_hl;
               r_lh <= w_lh;
               r_ll <= w_ll;
            end
         end

         r_s3_valid <= r_s2_valid;
         if (r_s2_valid)
            r_xy <= r_s2_mode ? {r_hh, r_ll} : w_sum;
      end
   end

   assign m_valid = r_s3_valid;
   assign m_xy    = r_xy;

endmodule

// File: tb/tb_barret_mul_feed.sv
// tb/tb_barret_mul_feed.sv - self-checking bench for barret_mul_feed
module tb_barret_mul_feed;
   import barret_mul_feed_pkg::*;

   localparam int NTBL = 10;

   logic                 clk;
   logic                 rst_n;
   logic                 s_valid;
   logic                 s_ready;
   logic [MAX_BW-1:0]    s_a;
   logic [MAX_BW-1:0]    s_b;
   logic                 m_valid;
   logic [PROD_BW-1:0]   m_xy;
   logic                 i_credit_ret;
   logic                 cfg_we;
   logic [MAX_BW-1:0]    cfg_q;
   logic [MAX_BW:0]      cfg_t;
   logic                 cfg_mode;
   logic [MAX_BW-1:0]    o_q;
   logic [MAX_BW:0]      o_t;
   logic                 o_mode;
   logic                 cfg_busy;
   logic                 cfg_done;
   logic                 err_credit;

   typedef struct {
      logic [MAX_BW-1:0]  a;
      logic [MAX_BW-1:0]  b;
      logic [PROD_BW-1:0] xy;
   } vec_t;

   typedef struct {
      logic [PROD_BW-1:0] xy;
      int                 due;
   } exp_t;

   vec_t  tbl [NTBL];
   exp_t  sb [$];
   int    n_vec;
   int    n_err;
   int    cyc;
   int    n_done;
   logic  auto_ret;

   barret_mul_feed #(.CREDITS(4), .CW(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_a          (s_a),
      .s_b          (s_b),
      .m_valid      (m_valid),
      .m_xy         (m_xy),
      .i_credit_ret (i_credit_ret),
      .cfg_we       (cfg_we),
      .cfg_q        (cfg_q),
      .cfg_t        (cfg_t),
      .cfg_mode     (cfg_mode),
      .o_q          (o_q),
      .o_t          (o_t),
      .o_mode       (o_mode),
      .cfg_busy     (cfg_busy),
      .cfg_done     (cfg_done),
      .err_credit   (err_credit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: each product must appear exactly at its due cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_m_valid", 1'b1, 1'b0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("m_xy", m_xy, e.xy);
               chk("m_valid_latency", cyc, e.due);
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("missing_m_valid", 1'b0, 1'b1);
         end
         if (cfg_done) n_done++;
      end
   end

   always @(negedge clk) if (auto_ret) i_credit_ret = m_valid;

   task automatic drive(input logic [MAX_BW-1:0] a, input logic [MAX_BW-1:0] b,
                        input logic [PROD_BW-1:0] xy, input logic ret);
      int w;
      w = 0;
      @(negedge clk);
      s_valid = 1'b1;
      s_a     = a;
      s_b     = b;
      if (ret) i_credit_ret = 1'b1;
      #1;
      while (!s_ready && w < 100) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk("accept_ready", s_ready, 1'b1);
      if (s_ready) sb.push_back('{xy, cyc + 3});
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      if (ret) i_credit_ret = 1'b0;
   endtask

   task automatic ret1();
      @(negedge clk);
      i_credit_ret = 1'b1;
      @(posedge clk);
      #1;
      i_credit_ret = 1'b0;
   endtask

   task automatic cfg_write(input logic [MAX_BW-1:0] q, input logic [MAX_BW:0] t, input logic mode);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_q    = q;
      cfg_t    = t;
      cfg_mode = mode;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [MAX_BW-1:0]  ra;
      logic [MAX_BW-1:0]  rb;
      logic [PROD_BW-1:0] ea;
      logic [PROD_BW-1:0] eb;
      logic [MAX_BW:0]    t1;
      logic [MAX_BW:0]    t2;
      logic [MAX_BW-1:0]  qn;

      n_vec = 0; n_err = 0; cyc = 0; n_done = 0; auto_ret = 1'b0;
      rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; i_credit_ret = 1'b0;
      cfg_we = 1'b0; cfg_q = '0; cfg_t = '0; cfg_mode = 1'b0;

      tbl[0] = '{62'd3, 62'd5, 124'd15};
      tbl[1] = '{{MAX_BW{1'b1}}, {MAX_BW{1'b1}}, 124'hFFFFFFFFFFFFFFF_8000000000000001};
      tbl[2] = '{62'h8000_0000, 62'h8000_0001, 124'h4000_0000_8000_0000};
      tbl[3] = '{62'h8000_0000, 62'h8000_0001, 124'h4000_0000_8000_0000};
      tbl[4] = '{62'd0, {MAX_BW{1'b1}}, 124'd0};
      tbl[5] = '{62'd1, {MAX_BW{1'b1}}, {62'd0, {MAX_BW{1'b1}}}};
      for (int i = 6; i < NTBL; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         ea = {62'd0, ra};
         eb = {62'd0, rb};
         tbl[i] = '{ra, rb, ea * eb};
      end

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_xy", m_xy, '0);
      chk("rst_o_q", o_q, '0);
      chk("rst_o_t", o_t, '0);
      chk("rst_o_mode", o_mode, 1'b0);
      chk("rst_cfg_busy", cfg_busy, 1'b0);
      chk("rst_cfg_done", cfg_done, 1'b0);
      chk("rst_err_credit", err_credit, 1'b0);
      chk("rst_s_ready", s_ready, 1'b1);

      // Table vectors back to back with downstream returning credits
      auto_ret = 1'b1;
      for (int i = 0; i < NTBL; i++) drive(tbl[i].a, tbl[i].b, tbl[i].xy, 1'b0);
      repeat (12) @(negedge clk);
      chk("table_drained", sb.size(), 0);
      auto_ret = 1'b0;
      i_credit_ret = 1'b0;

      // Credit exhaustion and simultaneous accept/return
      for (int i = 0; i < 4; i++) drive(62'd7 + i, 62'd2, {62'd0, 62'd14 + 62'(2*i)}, 1'b0);
      @(negedge clk); #1;
      chk("credit_empty_ready", s_ready, 1'b0);
      ret1();
      chk("credit_ret_ready", s_ready, 1'b1);
      drive(62'd11, 62'd13, 124'd143, 1'b1);
      chk("acc_ret_same_cycle_ready", s_ready, 1'b1);
      drive(62'd100, 62'd100, 124'd10000, 1'b0);
      chk("acc_ret_credit_stayed_1", s_ready, 1'b0);
      repeat (4) ret1();
      repeat (4) @(negedge clk);
      chk("credit_drained", sb.size(), 0);

      // Config write while two results are outstanding; second write wins
      qn = 62'h3FFF_FFFF_FFFF_FFC1;
      t1 = 63'h0_0000_000A_BCDE_F012;
      t2 = 63'h0_0000_0005_4321_0FED;
      drive(62'd2, 62'd3, 124'd6, 1'b0);
      drive(62'd4, 62'd5, 124'd20, 1'b0);
      cfg_write(qn, t1, 1'b0);
      chk("cfg_busy_set", cfg_busy, 1'b1);
      chk("cfg_s_ready_low", s_ready, 1'b0);
      cfg_write(qn, t2, 1'b0);
      repeat (6) @(negedge clk); #1;
      chk("cfg_wait_busy", cfg_busy, 1'b1);
      chk("cfg_wait_o_q", o_q, '0);
      chk("cfg_wait_done", n_done, 0);
      ret1();
      repeat (3) @(negedge clk); #1;
      chk("cfg_one_ret_busy", cfg_busy, 1'b1);
      chk("cfg_one_ret_ready", s_ready, 1'b0);
      ret1();
      repeat (3) @(negedge clk); #1;
      chk("cfg_applied_q", o_q, qn);
      chk("cfg_applied_t_last_wins", o_t, t2);
      chk("cfg_applied_busy", cfg_busy, 1'b0);
      chk("cfg_applied_ready", s_ready, 1'b1);
      chk("cfg_done_once", n_done, 1);
      chk("err_before", err_credit, 1'b0);
      ret1();
      chk("err_set", err_credit, 1'b1);
      repeat (3) @(negedge clk); #1;
      chk("err_sticky", err_credit, 1'b1);

      // Passthrough mode
      cfg_write(qn, t2, 1'b1);
      repeat (3) @(negedge clk); #1;
      chk("mode_applied", o_mode, 1'b1);
      chk("mode_done_count", n_done, 2);
      drive(62'h1234, 62'h5678, {62'h1234, 62'h5678}, 1'b0);
      repeat (5) @(negedge clk);
      ret1();
      chk("mode_drained", sb.size(), 0);

      // Reset with three products in flight
      drive(62'h11, 62'h22, {62'h11, 62'h22}, 1'b0);
      drive(62'h33, 62'h44, {62'h33, 62'h44}, 1'b0);
      drive(62'h55, 62'h66, {62'h55, 62'h66}, 1'b0);
      chk("pre_rst_m_valid", m_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_m_valid", m_valid, 1'b0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_s_ready", s_ready, 1'b1);
      chk("post_rst_o_q", o_q, '0);
      chk("post_rst_o_mode", o_mode, 1'b0);
      chk("post_rst_cfg_busy", cfg_busy, 1'b0);
      chk("post_rst_err", err_credit, 1'b0);
      repeat (6) @(negedge clk);
      for (int i = 0; i < 4; i++) drive(62'd9, 62'd3 + i, {62'd0, 62'd27 + 62'(9*i)}, 1'b0);
      @(negedge clk); #1;
      chk("post_rst_credit_4", s_ready, 1'b0);
      repeat (4) ret1();
      repeat (4) @(negedge clk);
      chk("final_drained", sb.size(), 0);
      chk("final_err", err_credit, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
